// File: rtl/hazard_detection_unit_pkg.sv
// Shared types and helpers for the hazard detection unit and its counters.
package hazard_detection_unit_pkg;

  localparam int unsigned ZERO_ADDRESS = 0;
  localparam int unsigned SAT_W        = 32;

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } hdu_state_e;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] max_value);
    sat_inc = (value >= max_value) ? max_value : value + SAT_W'(1);
  endfunction

endpackage

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter
  import hazard_detection_unit_pkg::*;
#(
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk,
  input  logic                inc,
  input  logic                clr,
  output logic [CntWidth-1:0] count
);

  localparam logic [SAT_W-1:0] MaxCount = SAT_W'({CntWidth{1'b1}});

  logic [CntWidth-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = CntWidth'(sat_inc(SAT_W'(count_q), MaxCount));
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard detection: load-use / branch-operand stalls, taken-branch
// flush, dmem-wait freeze with a sticky watchdog, and performance counters.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter int unsigned AddressSize = 5,
  parameter int unsigned MaxWait     = 64,
  parameter int unsigned CntWidth    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AddressSize-1:0] id_rs1,
  input  logic [AddressSize-1:0] id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic                   id_branch,
  input  logic                   branch_taken,
  input  logic [AddressSize-1:0] ex_rd,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_read,
  input  logic [AddressSize-1:0] mem_rd,
  input  logic                   mem_mem_read,
  input  logic                   mem_req,
  input  logic                   dmem_ready,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   id_ex_bubble,
  output logic                   if_id_flush,
  output logic                   freeze,
  output logic                   mem_timeout,
  output logic [CntWidth-1:0]    stall_cnt,
  output logic [CntWidth-1:0]    flush_cnt,
  output logic [CntWidth-1:0]    freeze_cnt
);

  localparam int unsigned            WaitWidth = $clog2(MaxWait + 1);
  localparam logic [AddressSize-1:0] ZeroAddr  = AddressSize'(ZERO_ADDRESS);

  hdu_state_e           state_q, state_d;
  logic [WaitWidth-1:0] wait_cnt_q, wait_cnt_d;
  logic                 mem_timeout_q, mem_timeout_d;

  logic load_use, br_ex, br_mem_load, data_stall;
  logic mem_wait, timeout_hit, timeout;

  // Hazard terms; a nonzero destination match implies a nonzero source.
  always_comb begin
    load_use    = ex_mem_read && (ex_rd != ZeroAddr) &&
                  ((id_uses_rs1 && (ex_rd == id_rs1)) || (id_uses_rs2 && (ex_rd == id_rs2)));
    br_ex       = id_branch && ex_reg_write && (ex_rd != ZeroAddr) &&
                  ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    br_mem_load = id_branch && mem_mem_read && (mem_rd != ZeroAddr) &&
                  ((mem_rd == id_rs1) || (mem_rd == id_rs2));
    data_stall  = load_use || br_ex || br_mem_load;
  end

  assign mem_wait    = mem_req && !dmem_ready;
  assign timeout_hit = mem_wait && (wait_cnt_q == WaitWidth'(MaxWait));
  assign timeout     = mem_timeout_q || timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Next state, watchdog and zero-latency control decode.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q || timeout_hit;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    if_id_flush   = 1'b0;
    freeze        = 1'b0;

    if (mem_wait) begin
      wait_cnt_d = WaitWidth'(sat_inc(SAT_W'(wait_cnt_q), SAT_W'(MaxWait)));
    end

    case (state_q)
      RUN:     if (mem_wait && !timeout) state_d = FREEZE;
      FREEZE:  if (!mem_wait || timeout) state_d = RUN;
      default: state_d = RUN;
    endcase

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else if (mem_wait && !timeout) begin
      freeze      = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (data_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;

  sat_counter #(.CntWidth(CntWidth)) u_stall_cnt (
    .clk   (clk),
    .inc   (data_stall && !freeze),
    .clr   (rst),
    .count (stall_cnt)
  );

  sat_counter #(.CntWidth(CntWidth)) u_flush_cnt (
    .clk   (clk),
    .inc   (if_id_flush),
    .clr   (rst),
    .count (flush_cnt)
  );

  sat_counter #(.CntWidth(CntWidth)) u_freeze_cnt (
    .clk   (clk),
    .inc   (freeze),
    .clr   (rst),
    .count (freeze_cnt)
  );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: vector table, directed multi-cycle
// sequences and random traffic, all against a cycle-level reference model.
module tb_hazard_detection_unit;

  localparam int unsigned AW        = 5;
  localparam int unsigned MAXW      = 64;
  localparam int unsigned CW        = 16;
  localparam int unsigned CWS       = 4;
  localparam int          CNT_MAX   = 65535;
  localparam int          CNT_MAX_S = 15;

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          id_uses_rs1;
    logic          id_uses_rs2;
    logic          id_branch;
    logic          branch_taken;
    logic [AW-1:0] ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic [AW-1:0] mem_rd;
    logic          mem_mem_read;
    logic          mem_req;
    logic          dmem_ready;
  } in_t;

  // {pc_write, if_id_write, id_ex_bubble, if_id_flush, freeze}
  typedef logic [4:0] dec_t;

  typedef struct {
    string name;
    in_t   in;
    dec_t  exp;
  } vec_t;

  logic clk;
  in_t  cur;

  logic          pc_write, if_id_write, id_ex_bubble, if_id_flush, freeze, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;
  logic          s_pc_write, s_if_id_write, s_id_ex_bubble, s_if_id_flush, s_freeze, s_mem_timeout;
  logic [CWS-1:0] s_stall_cnt, s_flush_cnt, s_freeze_cnt;

  int n_checks = 0;
  int n_err    = 0;

  int m_wait;
  bit m_to;
  int m_cnt[3];
  int m_cnt_s[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_detection_unit #(.AddressSize(AW), .MaxWait(MAXW), .CntWidth(CW)) dut (
    .clk(clk), .rst(cur.rst),
    .id_rs1(cur.id_rs1), .id_rs2(cur.id_rs2),
    .id_uses_rs1(cur.id_uses_rs1), .id_uses_rs2(cur.id_uses_rs2),
    .id_branch(cur.id_branch), .branch_taken(cur.branch_taken),
    .ex_rd(cur.ex_rd), .ex_reg_write(cur.ex_reg_write), .ex_mem_read(cur.ex_mem_read),
    .mem_rd(cur.mem_rd), .mem_mem_read(cur.mem_mem_read),
    .mem_req(cur.mem_req), .dmem_ready(cur.dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .freeze(freeze), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  // Narrow-counter copy to reach saturation quickly.
  hazard_detection_unit #(.AddressSize(AW), .MaxWait(MAXW), .CntWidth(CWS)) dut_s (
    .clk(clk), .rst(cur.rst),
    .id_rs1(cur.id_rs1), .id_rs2(cur.id_rs2),
    .id_uses_rs1(cur.id_uses_rs1), .id_uses_rs2(cur.id_uses_rs2),
    .id_branch(cur.id_branch), .branch_taken(cur.branch_taken),
    .ex_rd(cur.ex_rd), .ex_reg_write(cur.ex_reg_write), .ex_mem_read(cur.ex_mem_read),
    .mem_rd(cur.mem_rd), .mem_mem_read(cur.mem_mem_read),
    .mem_req(cur.mem_req), .dmem_ready(cur.dmem_ready),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .id_ex_bubble(s_id_ex_bubble),
    .if_id_flush(s_if_id_flush), .freeze(s_freeze), .mem_timeout(s_mem_timeout),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .freeze_cnt(s_freeze_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic in_t mk(input int rs1, input int rs2, input int u1, input int u2,
                             input int br, input int bt, input int exrd, input int exw,
                             input int exm, input int memrd, input int memm,
                             input int req, input int rdy, input int r);
    in_t t;
    t.id_rs1 = 5'(rs1);       t.id_rs2 = 5'(rs2);
    t.id_uses_rs1 = 1'(u1);   t.id_uses_rs2 = 1'(u2);
    t.id_branch = 1'(br);     t.branch_taken = 1'(bt);
    t.ex_rd = 5'(exrd);       t.ex_reg_write = 1'(exw);  t.ex_mem_read = 1'(exm);
    t.mem_rd = 5'(memrd);     t.mem_mem_read = 1'(memm);
    t.mem_req = 1'(req);      t.dmem_ready = 1'(rdy);    t.rst = 1'(r);
    return t;
  endfunction

  // A branch compared in ID needs any producer of either operand to be done.
  function automatic bit branch_needs(input logic [AW-1:0] rd);
    return cur.id_branch && (rd != 0) && ((rd == cur.id_rs1) || (rd == cur.id_rs2));
  endfunction

  task automatic model(output dec_t e, output bit stall);
    bit lu, waiting, to;
    lu = cur.ex_mem_read && (cur.ex_rd != 0) &&
         ((cur.id_uses_rs1 && cur.ex_rd == cur.id_rs1) || (cur.id_uses_rs2 && cur.ex_rd == cur.id_rs2));
    stall   = lu || (cur.ex_reg_write && branch_needs(cur.ex_rd)) ||
              (cur.mem_mem_read && branch_needs(cur.mem_rd));
    waiting = cur.mem_req && !cur.dmem_ready;
    to      = m_to || (waiting && m_wait == MAXW);
    if (cur.rst)               e = 5'b00110;
    else if (waiting && !to)   e = 5'b00001;
    else if (stall)            e = 5'b00100;
    else if (cur.branch_taken) e = 5'b11010;
    else                       e = 5'b11000;
  endtask

  function automatic void bump(input int k);
    if (m_cnt[k] < CNT_MAX) m_cnt[k]++;
    if (m_cnt_s[k] < CNT_MAX_S) m_cnt_s[k]++;
  endfunction

  // One clock cycle with the inputs in cur; entered and left at negedge.
  task automatic step(input string tag, input bit chk, input dec_t want);
    dec_t e, act;
    bit   stall, waiting;
    #1;
    model(e, stall);
    waiting = cur.mem_req && !cur.dmem_ready;
    act = {pc_write, if_id_write, id_ex_bubble, if_id_flush, freeze};
    check({tag, "/decode"}, 32'(act), 32'(e));
    if (chk) check({tag, "/expect"}, 32'(act), 32'(want));
    check({tag, "/mem_timeout"}, 32'(mem_timeout), 32'(m_to));
    check({tag, "/stall_cnt"},  32'(stall_cnt),  32'(m_cnt[0]));
    check({tag, "/flush_cnt"},  32'(flush_cnt),  32'(m_cnt[1]));
    check({tag, "/freeze_cnt"}, 32'(freeze_cnt), 32'(m_cnt[2]));
    check({tag, "/s_stall_cnt"},  32'(s_stall_cnt),  32'(m_cnt_s[0]));
    check({tag, "/s_flush_cnt"},  32'(s_flush_cnt),  32'(m_cnt_s[1]));
    check({tag, "/s_freeze_cnt"}, 32'(s_freeze_cnt), 32'(m_cnt_s[2]));
    @(posedge clk);
    if (cur.rst) begin
      m_wait = 0;
      m_to   = 1'b0;
      for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; m_cnt_s[k] = 0; end
    end else begin
      if (waiting && m_wait == MAXW) m_to = 1'b1;
      m_wait = waiting ? m_wait + 1 : 0;
      if (stall && !e[0]) bump(0);
      if (e[1]) bump(1);
      if (e[0]) bump(2);
    end
    @(negedge clk);
  endtask

  vec_t vecs[$];
  in_t  idle, rst_idle;

  initial begin
    idle     = mk(0,0,0,0,0,0, 0,0,0, 0,0, 0,1, 0);
    rst_idle = mk(0,0,0,0,0,0, 0,0,0, 0,0, 0,1, 1);
    m_wait = 0; m_to = 1'b0;
    for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; m_cnt_s[k] = 0; end

    vecs.push_back('{"idle",         idle,                                     5'b11000});
    vecs.push_back('{"lu_rs2",       mk(1,5,1,1,0,0, 5,1,1, 0,0, 0,1, 0), 5'b00100});
    vecs.push_back('{"lu_unused",    mk(5,2,0,1,0,0, 5,1,1, 0,0, 0,1, 0), 5'b11000});
    vecs.push_back('{"lu_x0",        mk(0,0,1,1,0,0, 0,1,1, 0,0, 0,1, 0), 5'b11000});
    vecs.push_back('{"taken",        mk(1,2,1,1,1,1, 0,0,0, 0,0, 0,1, 0), 5'b11010});
    vecs.push_back('{"taken_stall",  mk(6,2,1,1,1,1, 6,1,1, 0,0, 0,1, 0), 5'b00100});
    vecs.push_back('{"br_ex_alu",    mk(1,3,0,0,1,0, 3,1,0, 0,0, 0,1, 0), 5'b00100});
    vecs.push_back('{"br_mem_load",  mk(4,1,1,1,1,0, 0,0,0, 4,1, 0,1, 0), 5'b00100});
    vecs.push_back('{"mem_ld_nobr",  mk(4,1,1,1,0,0, 0,0,0, 4,1, 0,1, 0), 5'b11000});
    vecs.push_back('{"br_x0",        mk(0,0,1,1,1,0, 0,1,0, 0,1, 0,1, 0), 5'b11000});
    vecs.push_back('{"br_mem_alu",   mk(4,1,1,1,1,0, 0,0,0, 4,0, 0,1, 0), 5'b11000});
    vecs.push_back('{"wait_lu",      mk(1,5,1,1,0,0, 5,1,1, 0,0, 1,0, 0), 5'b00001});
    vecs.push_back('{"req_ready_lu", mk(1,5,1,1,0,0, 5,1,1, 0,0, 1,1, 0), 5'b00100});
    vecs.push_back('{"rst_hazard",   mk(1,5,1,1,1,1, 5,1,1, 0,0, 1,0, 1), 5'b00110});

    // Reset through one edge so the registered state is defined.
    cur = rst_idle;
    @(negedge clk);
    @(negedge clk);
    step("reset", 1'b1, 5'b00110);

    foreach (vecs[i]) begin
      cur = vecs[i].in;
      step(vecs[i].name, 1'b1, vecs[i].exp);
    end

    // Single load-use stall and a single flush right after reset.
    cur = mk(1,5,1,1,0,0, 5,1,1, 0,0, 0,1, 0); step("seq_lu", 1'b1, 5'b00100);
    cur = mk(1,2,1,1,1,1, 0,0,0, 0,0, 0,1, 0); step("seq_taken", 1'b1, 5'b11010);
    cur = idle;                                step("seq_idle", 1'b1, 5'b11000);
    check("stall_cnt_one", 32'(stall_cnt), 32'd1);
    check("flush_cnt_one", 32'(flush_cnt), 32'd1);

    // Branch on a load in EX: two stalls, then it resolves.
    cur = mk(7,0,1,0,1,1, 7,1,1, 0,0, 0,1, 0); step("ldbr_ex", 1'b1, 5'b00100);
    cur = mk(7,0,1,0,1,1, 0,0,0, 7,1, 0,1, 0); step("ldbr_mem", 1'b1, 5'b00100);
    cur = mk(7,0,1,0,1,1, 0,0,0, 0,0, 0,1, 0); step("ldbr_go", 1'b1, 5'b11010);
    // Branch on an ALU result: one stall.
    cur = mk(7,0,1,0,1,1, 7,1,0, 0,0, 0,1, 0); step("alubr_ex", 1'b1, 5'b00100);
    cur = mk(7,0,1,0,1,1, 0,0,0, 7,0, 0,1, 0); step("alubr_go", 1'b1, 5'b11010);

    // Three dmem wait cycles with a pending load-use.
    cur = rst_idle; step("frz_rst", 1'b1, 5'b00110);
    for (int k = 0; k < 3; k++) begin
      cur = mk(1,5,1,1,0,0, 5,1,1, 0,0, 1,0, 0); step("frz_wait", 1'b1, 5'b00001);
    end
    cur = mk(1,5,1,1,0,0, 5,1,1, 0,0, 1,1, 0); step("frz_done_lu", 1'b1, 5'b00100);
    cur = idle;                                step("frz_idle", 1'b1, 5'b11000);
    check("freeze_cnt_three", 32'(freeze_cnt), 32'd3);
    check("stall_cnt_after_freeze", 32'(stall_cnt), 32'd1);

    // Hung memory: watchdog fires on the 65th wait cycle.
    cur = rst_idle; step("to_rst", 1'b1, 5'b00110);
    for (int k = 1; k <= 70; k++) begin
      cur = mk(0,0,0,0,0,0, 0,0,0, 0,0, 1,0, 0);
      step($sformatf("to_wait%0d", k), 1'b1, (k <= 64) ? 5'b00001 : 5'b11000);
    end
    check("timeout_set", 32'(mem_timeout), 32'd1);
    check("timeout_freeze_cnt", 32'(freeze_cnt), 32'd64);
    check("sat_freeze_cnt", 32'(s_freeze_cnt), 32'd15);
    cur = idle; step("to_idle", 1'b1, 5'b11000);
    check("timeout_sticky", 32'(mem_timeout), 32'd1);
    cur = rst_idle; step("to_clear", 1'b1, 5'b00110);
    check("timeout_cleared", 32'(mem_timeout), 32'd0);
    check("stall_cnt_zero", 32'(stall_cnt), 32'd0);
    check("flush_cnt_zero", 32'(flush_cnt), 32'd0);
    check("freeze_cnt_zero", 32'(freeze_cnt), 32'd0);

    // Random traffic on a small register set to make matches frequent.
    for (int i = 0; i < 800; i++) begin
      cur.rst          = ($urandom_range(0, 99) == 0);
      cur.id_rs1       = 5'($urandom_range(0, 3));
      cur.id_rs2       = 5'($urandom_range(0, 3));
      cur.id_uses_rs1  = 1'($urandom_range(0, 1));
      cur.id_uses_rs2  = 1'($urandom_range(0, 1));
      cur.id_branch    = ($urandom_range(0, 2) == 0);
      cur.branch_taken = 1'($urandom_range(0, 1));
      cur.ex_rd        = 5'($urandom_range(0, 3));
      cur.ex_reg_write = 1'($urandom_range(0, 1));
      cur.ex_mem_read  = ($urandom_range(0, 2) == 0);
      cur.mem_rd       = 5'($urandom_range(0, 3));
      cur.mem_mem_read = ($urandom_range(0, 2) == 0);
      cur.mem_req      = ($urandom_range(0, 3) == 0);
      cur.dmem_ready   = 1'($urandom_range(0, 1));
      step("rand", 1'b0, 5'b00000);
    end
    check("sat_stall_cnt", 32'(s_stall_cnt), 32'(m_cnt_s[0]));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Detects pipeline hazards in the 5-stage core and drives the stall, bubble, flush and freeze controls.
- Consumer-side complement of the forwarding logic: it covers every case forwarding cannot resolve. These are load-use, branch-compare-in-ID dependences, taken-branch flush and data-memory wait.
- Sits beside the ID stage. It also keeps a data-memory wait watchdog and saturating performance counters.

Parameters:
- AddressSize, 5, register address width
- MaxWait, 64, maximum consecutive dmem wait cycles before timeout
- CntWidth, 16, width of each performance counter

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  AddressSize  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2
- id_branch  in  1  ID instruction is a branch compared in ID
- branch_taken  in  1  ID compare/jump resolves taken
- ex_rd  in  AddressSize  EX-stage destination
- ex_reg_write, ex_mem_read  in  1  EX-stage control
- mem_rd  in  AddressSize  MEM-stage destination
- mem_mem_read  in  1  MEM-stage instruction is a load
- mem_req  in  1  MEM stage is issuing a load or store
- dmem_ready  in  1  data memory completes this cycle
- pc_write  out  1  PC may update
- if_id_write  out  1  IF/ID register may update
- id_ex_bubble  out  1  load a NOP into ID/EX
- if_id_flush  out  1  clear IF/ID (squash the fetched instruction)
- freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
- mem_timeout  out  1  sticky watchdog error
- stall_cnt, flush_cnt, freeze_cnt  out  CntWidth  performance counters

Behaviour:
- Register matches exclude address 0. Each match requires the corresponding id_uses_rsX, or id_branch, as stated per term.
- load_use: ex_mem_read and ex_rd matches a used rs.
- br_ex: id_branch, ex_reg_write, and ex_rd matches rs1 or rs2. This applies to loads and ALU ops alike.
- br_mem_load: id_branch, mem_mem_read, and mem_rd matches rs1 or rs2.
- data_stall = load_use | br_ex | br_mem_load.
- A branch that depends on a load in EX therefore stalls 2 cycles: br_ex, then br_mem_load. A branch that depends on an ALU op in EX stalls 1 cycle.
- mem_wait = mem_req & ~dmem_ready.
- FSM states: RUN and FREEZE.
  - RUN -> FREEZE when mem_wait.
  - FREEZE -> RUN when dmem_ready or on timeout.
- Output decode for the current cycle, highest priority first:
  - rst: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=1, freeze=0.
  - mem_wait (either state) and no timeout: freeze=1, pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0.
  - data_stall: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0. branch_taken is ignored because the operands are invalid.
  - branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=0.
  - otherwise: pc_write=1, if_id_write=1, all other outputs 0.
- The decode is purely combinational from inputs and state, with zero latency.
- Watchdog wait_cnt, width clog2(MaxWait+1):
  - Increments each cycle mem_wait is high.
  - Clears when mem_wait is low.
- Timeout: when wait_cnt==MaxWait and mem_wait is still high:
  - mem_timeout sets and stays set until rst.
  - The FSM returns to RUN.
  - freeze is forced to 0 from then on, so a hung memory no longer deadlocks the core. Downstream traps on mem_timeout.
- Counters: stall_cnt counts cycles with data_stall that are not frozen; flush_cnt counts if_id_flush cycles outside reset; freeze_cnt counts freeze cycles.
  - All three saturate at all-ones with no wrap.
  - All three are 0 after rst.
- Reset mid-FREEZE returns to RUN with wait_cnt=0 and mem_timeout=0. Reset asserted in the same cycle as a hazard takes priority over the hazard.

Decomposition:
- Shared package: ZERO_ADDRESS, FSM state encoding (RUN, FREEZE), and the saturating-increment function.
- One natural sub-module, sat_counter (parameter CntWidth, inputs inc/clr), instantiated three times.

Test Plan:
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt=1.
- Load x7 in EX, branch in ID reading x7 -> 2 consecutive stall cycles (br_ex, then br_mem_load). An ALU writing x7 instead -> exactly 1 stall.
- ex_rd=0, ex_mem_read=1, id_rs1=0 -> no stall.
- branch_taken=1, no hazard -> if_id_flush=1 for 1 cycle, flush_cnt=1.
- branch_taken=1 during a data_stall -> no flush.
- mem_req=1, dmem_ready low for 3 cycles -> freeze=1 for exactly 3 cycles, freeze_cnt=3, back to RUN; load_use asserted meanwhile produces no bubble until the freeze drops.
- dmem_ready held low for 70 cycles with MaxWait=64 -> mem_timeout rises after 65 wait cycles and freeze drops to 0. Then rst -> mem_timeout=0, all counters 0. Counter at 16'hFFFF with further stalls -> stays 16'hFFFF.
